// File: rtl/cache_axi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_axi_bridge
// Purpose  : Turns the cache miss-handling interface (refill reads on
//            rd_req/ret_*, write-backs on wr_req/wr_*) into AXI4 master
//            transactions. Allows one outstanding read and one outstanding
//            write. A read is held off while a write to the same 16-byte
//            line is in flight, so a refill cannot overtake the write-back
//            of that line.
// Ports    : clk, resetn (async, active-low)
//            Cache read  : rd_req, rd_type, rd_addr -> rd_rdy,
//                          ret_valid, ret_last, ret_data
//            Cache write : wr_req, wr_type, wr_addr, wr_wstrb, wr_data
//                          -> wr_rdy
//            AXI master  : AR, R, AW, W and B channels (ID width 4,
//                          address 32, data 32)
// Revision : 1.0 - initial release
// ============================================================================
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    // cache read request / return
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    // cache write request
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    // AXI read address
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    // AXI read data
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    // AXI write address
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    // AXI write data
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    // AXI write response
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [2:0] c_TYPE_LINE = 3'b100;
    localparam logic [1:0] c_BURST_INCR = 2'b01;

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_AR   = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_SEND = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]   r_rd_state;
    logic [1:0]   w_rd_state_nxt;
    logic [31:0]  r_rd_addr;
    logic [2:0]   r_rd_type;

    logic [1:0]   r_wr_state;
    logic [1:0]   w_wr_state_nxt;
    logic [31:0]  r_wr_addr;
    logic [2:0]   r_wr_type;
    logic [3:0]   r_wr_strb;
    logic [127:0] r_wr_data;
    logic [1:0]   r_cnt;
    logic         r_aw_done;
    logic         r_w_done;

    logic         w_rd_accept;
    logic         w_wr_accept;
    logic         w_hazard;
    logic         w_rd_line;
    logic         w_wr_line;
    logic         w_aw_done_now;
    logic         w_w_done_now;

    // Response IDs and response codes carry no information the cache needs.
    logic         w_unused_ok;
    assign w_unused_ok = &{1'b0, rid, rresp, bid, bresp};

    assign w_rd_accept = rd_req && rd_rdy;
    assign w_wr_accept = wr_req && wr_rdy;
    assign w_rd_line   = (r_rd_type == c_TYPE_LINE);
    assign w_wr_line   = (r_wr_type == c_TYPE_LINE);

    // Same-line hazard: either a write to this line is already in flight,
    // or one is being accepted in this very cycle. The second term keeps a
    // simultaneous read/write pair to one line from racing each other.
    assign w_hazard = ((r_wr_state != c_W_IDLE) && (rd_addr[31:4] == r_wr_addr[31:4])) ||
                      (w_wr_accept && (rd_addr[31:4] == wr_addr[31:4]));

    // ==================================================================
    // Read FSM
    // ==================================================================
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_state <= c_R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            c_R_IDLE: if (w_rd_accept)      w_rd_state_nxt = c_R_AR;
            c_R_AR:   if (arready)          w_rd_state_nxt = c_R_DATA;
            c_R_DATA: if (rvalid && rlast)  w_rd_state_nxt = c_R_IDLE;
            default:                        w_rd_state_nxt = c_R_IDLE;
        endcase
    end

    always_comb begin
        rd_rdy  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (r_rd_state)
            c_R_IDLE: rd_rdy  = !w_hazard;
            c_R_AR:   arvalid = 1'b1;
            c_R_DATA: rready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_addr <= '0;
            r_rd_type <= '0;
        end else if (w_rd_accept) begin
            r_rd_addr <= rd_addr;
            r_rd_type <= rd_type;
        end
    end

    assign arid    = RD_ID;
    assign araddr  = r_rd_addr;
    assign arlen   = w_rd_line ? 8'd3 : 8'd0;
    assign arsize  = w_rd_line ? 3'd2 : {1'b0, r_rd_type[1:0]};
    assign arburst = c_BURST_INCR;

    // Returned beats are passed straight through while in the data phase.
    assign ret_valid = rready && rvalid;
    assign ret_last  = rready && rlast;
    assign ret_data  = rdata;

    // ==================================================================
    // Write FSM
    // ==================================================================
    // AW and W progress independently; a handshake completing in this
    // cycle counts towards leaving W_SEND so no idle cycle is wasted.
    assign w_aw_done_now = r_aw_done || (awvalid && awready);
    assign w_w_done_now  = r_w_done  || (wvalid && wready && wlast);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_state <= c_W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            c_W_IDLE: if (w_wr_accept)                    w_wr_state_nxt = c_W_SEND;
            c_W_SEND: if (w_aw_done_now && w_w_done_now)  w_wr_state_nxt = c_W_RESP;
            c_W_RESP: if (bvalid)                         w_wr_state_nxt = c_W_IDLE;
            default:                                      w_wr_state_nxt = c_W_IDLE;
        endcase
    end

    always_comb begin
        wr_rdy  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (r_wr_state)
            c_W_IDLE: wr_rdy = 1'b1;
            c_W_SEND: begin
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
            end
            c_W_RESP: bready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_addr <= '0;
            r_wr_type <= '0;
            r_wr_strb <= '0;
            r_wr_data <= '0;
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_wr_accept) begin
            r_wr_addr <= wr_addr;
            r_wr_type <= wr_type;
            r_wr_strb <= wr_wstrb;
            r_wr_data <= wr_data;
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_wr_state == c_W_SEND) begin
            if (awvalid && awready) begin
                r_aw_done <= 1'b1;
            end
            if (wvalid && wready) begin
                r_cnt <= r_cnt + 2'd1;
                if (wlast) begin
                    r_w_done <= 1'b1;
                end
            end
        end
    end

    assign awid    = WR_ID;
    assign awaddr  = r_wr_addr;
    assign awlen   = w_wr_line ? 8'd3 : 8'd0;
    assign awsize  = w_wr_line ? 3'd2 : {1'b0, r_wr_type[1:0]};
    assign awburst = c_BURST_INCR;

    // Beat data comes from the latched line, lowest word first.
    always_comb begin
        case (r_cnt)
            2'd0:    wdata = r_wr_data[31:0];
            2'd1:    wdata = r_wr_data[63:32];
            2'd2:    wdata = r_wr_data[95:64];
            default: wdata = r_wr_data[127:96];
        endcase
    end

    // Full-line write-backs always write every byte; partial writes use
    // the strobes captured with the request.
    assign wstrb = w_wr_line ? 4'hf : r_wr_strb;
    assign wlast = (r_cnt == awlen[1:0]);

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_axi_bridge
// Purpose  : Self-checking bench for cache_axi_bridge. A request driver
//            pushes expected AXI transfers and returned beats into queues;
//            a monitor pops and compares them as the DUT presents them, and
//            tracks transaction-level busy/ready expectations each cycle.
//            A small AXI slave model with randomised ready/valid timing
//            answers the bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_axi_bridge;

    logic         clk, resetn;
    logic         rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr, ret_data;
    logic         wr_req, wr_rdy;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic [3:0]   arid, rid, awid, bid;
    logic [31:0]  araddr, rdata, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    cache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } addr_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    addr_exp_t ar_q[$];
    addr_exp_t aw_q[$];
    beat_t     ret_q[$];
    beat_t     w_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Read data the slave returns for beat i of a burst starting at a.
    function automatic logic [31:0] rfn(input logic [31:0] a, input int i);
        if (a == 32'h1C000040) return 32'hA0 + 32'(i);
        return (a * 32'h9E3779B1) ^ (32'(i) << 24) ^ 32'h5A5A0000;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: what one accepted cache request must become on AXI
    // ------------------------------------------------------------------
    task automatic push_rd(input logic [31:0] a, input logic [2:0] t);
        int n;
        n = (t == 3'b100) ? 4 : 1;
        ar_q.push_back('{a, 8'(n - 1), (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]}});
        for (int i = 0; i < n; i++) ret_q.push_back('{rfn(a, i), 4'h0, i == n - 1});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [2:0] t,
                           input logic [3:0] s, input logic [127:0] d);
        int n;
        n = (t == 3'b100) ? 4 : 1;
        aw_q.push_back('{a, 8'(n - 1), (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]}});
        for (int i = 0; i < n; i++)
            w_q.push_back('{d[32*i +: 32], (t == 3'b100) ? 4'hf : s, i == n - 1});
    endtask

    // ------------------------------------------------------------------
    // AXI slave model (drives at posedge+2, observes at negedge)
    // ------------------------------------------------------------------
    int unsigned ar_pct = 100, r_pct = 100, aw_pct = 100, w_pct = 100;
    int          aw_hold = 0, b_delay_max = 0, s_bwait = 0;
    logic        s_rbusy = 1'b0, s_aw = 1'b0, s_wl = 1'b0;
    logic [31:0] s_raddr = '0;
    int          s_rn = 1, s_ri = 0;

    initial begin
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rid = 4'd0; rresp = 2'b00;
        awready = 0; wready = 0; bvalid = 0; bid = 4'd1; bresp = 2'b00;
        forever begin
            @(posedge clk); #2;
            arready = !s_rbusy && ($urandom_range(0, 99) < ar_pct);
            rvalid  = s_rbusy && ($urandom_range(0, 99) < r_pct);
            rdata   = rfn(s_raddr, s_ri);
            rlast   = (s_ri == s_rn - 1);
            if (aw_hold > 0) begin
                awready = 1'b0;
                aw_hold--;
            end else begin
                awready = ($urandom_range(0, 99) < aw_pct);
            end
            wready = ($urandom_range(0, 99) < w_pct);
            bvalid = s_aw && s_wl && (s_bwait == 0);
            if (s_aw && s_wl && s_bwait > 0) s_bwait--;
            @(negedge clk);
            if (!resetn) begin
                s_rbusy = 0; s_aw = 0; s_wl = 0; s_ri = 0;
            end else begin
                if (arvalid && arready) begin
                    s_rbusy = 1; s_raddr = araddr; s_rn = int'(arlen) + 1; s_ri = 0;
                end
                if (rvalid && rready) begin
                    if (rlast) s_rbusy = 0;
                    s_ri++;
                end
                if (awvalid && awready)         s_aw = 1;
                if (wvalid && wready && wlast)  s_wl = 1;
                if (bvalid && bready) begin
                    s_aw = 0; s_wl = 0;
                    s_bwait = $urandom_range(0, b_delay_max);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: transaction-level tracking plus queue comparison
    // ------------------------------------------------------------------
    logic        m_rd_busy = 0, m_ar_seen = 0;
    logic        m_wr_busy = 0, m_aw_seen = 0, m_wl_seen = 0;
    logic [27:0] m_wr_line = '0;

    always @(negedge clk) begin
        addr_exp_t e;
        beat_t     b;
        logic      exp_rd_rdy;
        if (!resetn) begin
            ar_q.delete(); aw_q.delete(); ret_q.delete(); w_q.delete();
            m_rd_busy = 0; m_ar_seen = 0; m_wr_busy = 0; m_aw_seen = 0; m_wl_seen = 0;
        end else begin
            // A read may start only when no read is running and no write
            // to its line is in flight or being accepted right now.
            exp_rd_rdy = !m_rd_busy &&
                         !(m_wr_busy && rd_addr[31:4] == m_wr_line) &&
                         !(wr_req && !m_wr_busy && rd_addr[31:4] == wr_addr[31:4]);
            chk("ctrl{rd_rdy,wr_rdy,arv,rrdy,awv,wv,brdy,retv}",
                {24'h0, rd_rdy, wr_rdy, arvalid, rready, awvalid, wvalid, bready, ret_valid},
                {24'h0, exp_rd_rdy, !m_wr_busy, m_rd_busy && !m_ar_seen, m_rd_busy && m_ar_seen,
                 m_wr_busy && !m_aw_seen, m_wr_busy && !m_wl_seen,
                 m_wr_busy && m_aw_seen && m_wl_seen, rvalid && m_rd_busy && m_ar_seen});

            if (arvalid && arready) begin
                if (ar_q.size() == 0) chk("ar_unexpected", arvalid, 0);
                else begin
                    e = ar_q.pop_front();
                    chk("araddr", araddr, e.addr);
                    chk("ar{len,size,burst,id}", {14'h0, arlen, arsize, arburst, arid},
                        {14'h0, e.len, e.size, 2'b01, 4'd0});
                end
                m_ar_seen = 1;
            end
            if (ret_valid) begin
                if (ret_q.size() == 0) chk("ret_unexpected", ret_valid, 0);
                else begin
                    b = ret_q.pop_front();
                    chk("ret_data", ret_data, b.data);
                    chk("ret_last", ret_last, b.last);
                end
            end
            if (rvalid && rready && rlast) m_rd_busy = 0;
            if (awvalid && awready) begin
                if (aw_q.size() == 0) chk("aw_unexpected", awvalid, 0);
                else begin
                    e = aw_q.pop_front();
                    chk("awaddr", awaddr, e.addr);
                    chk("aw{len,size,burst,id}", {14'h0, awlen, awsize, awburst, awid},
                        {14'h0, e.len, e.size, 2'b01, 4'd1});
                end
                m_aw_seen = 1;
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) chk("w_unexpected", wvalid, 0);
                else begin
                    b = w_q.pop_front();
                    chk("wdata", wdata, b.data);
                    chk("w{strb,last}", {27'h0, wstrb, wlast}, {27'h0, b.strb, b.last});
                end
                if (wlast) m_wl_seen = 1;
            end
            if (bvalid && bready) m_wr_busy = 0;
            if (rd_req && rd_rdy) begin m_rd_busy = 1; m_ar_seen = 0; end
            if (wr_req && wr_rdy) begin
                m_wr_busy = 1; m_wr_line = wr_addr[31:4]; m_aw_seen = 0; m_wl_seen = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request driver
    // ------------------------------------------------------------------
    task automatic step();
        logic ra, wa;
        @(negedge clk);
        ra = rd_req && rd_rdy;
        wa = wr_req && wr_rdy;
        if (ra) push_rd(rd_addr, rd_type);
        if (wa) push_wr(wr_addr, wr_type, wr_wstrb, wr_data);
        @(posedge clk); #1;
        if (ra) rd_req = 0;
        if (wa) wr_req = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && (rd_req || wr_req || m_rd_busy || m_wr_busy); k++) step();
        chk("idle_timeout", {28'h0, rd_req, wr_req, m_rd_busy, m_wr_busy}, 0);
    endtask

    task automatic wait_bready();
        for (int k = 0; k < 50 && !bready; k++) step();
        chk("wait_bready", bready, 1);
    endtask

    task automatic issue_rd(input logic [31:0] a, input logic [2:0] t);
        rd_addr = a; rd_type = t; rd_req = 1;
    endtask

    task automatic issue_wr(input logic [31:0] a, input logic [2:0] t,
                            input logic [3:0] s, input logic [127:0] d);
        wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d; wr_req = 1;
    endtask

    function automatic logic [2:0] rand_type();
        case ($urandom_range(0, 3))
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr(input logic [2:0] t);
        logic [31:0] base;
        base = 32'h0000_1000 | (32'($urandom_range(0, 7)) << 4);
        case (t)
            3'b000:  return base | 32'($urandom_range(0, 15));
            3'b001:  return base | (32'($urandom_range(0, 7)) << 1);
            3'b010:  return base | (32'($urandom_range(0, 3)) << 2);
            default: return base;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t;
        resetn = 0; rd_req = 0; rd_type = '0; rd_addr = '0;
        wr_req = 0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset{rd_rdy,wr_rdy,arv,rrdy,awv,wv,brdy,retv}",
            {24'h0, rd_rdy, wr_rdy, arvalid, rready, awvalid, wvalid, bready, ret_valid},
            32'h0000_00C0);
        chk("reset_ret_last", ret_last, 0);
        @(posedge clk); #1;
        resetn = 1;

        // Line refill returning 0xA0..0xA3
        issue_rd(32'h1C000040, 3'b100);
        wait_idle();

        // Line write-back, strobes from the request must be ignored
        issue_wr(32'h00001230, 3'b100, 4'h3, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        wait_idle();

        // AW held off while W streams through
        aw_hold = 6;
        issue_wr(32'h00002000, 3'b100, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11});
        wait_idle();

        // Same-line hazard: read to 0x84 waits for the write to 0x80
        s_bwait = 6;
        issue_wr(32'h00000080, 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom});
        step();
        wait_bready();
        issue_rd(32'h00000084, 3'b010);
        for (int k = 0; k < 30 && rd_req; k++) step();
        chk("hazard_read_accepted", rd_req, 0);
        wait_idle();

        // Different line during the same window goes straight through
        s_bwait = 6;
        issue_wr(32'h00000080, 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom});
        step();
        wait_bready();
        issue_rd(32'h00000100, 3'b100);
        step();
        chk("other_line_accept_now", rd_req, 0);
        wait_idle();

        // Word read and byte write
        issue_rd(32'h1FAF0004, 3'b010);
        issue_wr(32'h00000402, 3'b000, 4'b0100, {96'h0, 32'h00AB0000});
        wait_idle();

        // Randomised concurrent traffic
        ar_pct = 50; r_pct = 50; aw_pct = 50; w_pct = 50; b_delay_max = 3;
        for (int c = 0; c < 1500; c++) begin
            if (!rd_req && $urandom_range(0, 3) == 0) begin
                t = rand_type();
                issue_rd(rand_addr(t), t);
            end
            if (!wr_req && $urandom_range(0, 3) == 0) begin
                t = rand_type();
                issue_wr(rand_addr(t), t, 4'($urandom),
                         {$urandom, $urandom, $urandom, $urandom});
            end
            step();
        end
        wait_idle();
        chk("leftover_expectations", ar_q.size() + ret_q.size() + aw_q.size() + w_q.size(), 0);

        // Reset in the middle of a read data phase
        ar_pct = 100; r_pct = 0;
        issue_rd(32'h00000200, 3'b100);
        step();
        for (int k = 0; k < 20 && !rready; k++) step();
        chk("reach_rdata_phase", rready, 1);
        r_pct = 100;
        @(posedge clk); #3;
        chk("pre_reset_ret_valid", ret_valid, 1);
        resetn = 0;
        #1;
        chk("reset_rready", rready, 0);
        chk("reset_ret_valid", ret_valid, 0);
        @(negedge clk);
        @(posedge clk); #1;
        resetn = 1;
        chk("post_reset_rd_rdy", rd_rdy, 1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
